// File: rtl/hazard_controller_if.sv
// Pipeline observation / control bundle between the MIPS datapath and hazard_controller.
// The datapath side uses the master modport; the controller uses slave.
interface hazard_controller_if;
    logic [4:0] IDRs, IDRt;
    logic       IDUsesRt;
    logic [4:0] EXRs, EXRt, EXRd;
    logic       EXRegWrite, EXMemRead;
    logic [4:0] MEMRd;
    logic       MEMRegWrite;
    logic [4:0] WBRd;
    logic       WBRegWrite;
    logic       BranchTaken, JumpEX;
    logic       PCWrite, IFIDWrite, IDEXBubble;
    logic       IFIDFlush, IDEXFlush, EXMEMFlush;
    logic [1:0] ForwardA, ForwardB;
    logic [1:0] HazState;

    modport master (
        output IDRs, IDRt, IDUsesRt, EXRs, EXRt, EXRd, EXRegWrite, EXMemRead,
               MEMRd, MEMRegWrite, WBRd, WBRegWrite, BranchTaken, JumpEX,
        input  PCWrite, IFIDWrite, IDEXBubble, IFIDFlush, IDEXFlush, EXMEMFlush,
               ForwardA, ForwardB, HazState
    );

    modport slave (
        input  IDRs, IDRt, IDUsesRt, EXRs, EXRt, EXRd, EXRegWrite, EXMemRead,
               MEMRd, MEMRegWrite, WBRd, WBRegWrite, BranchTaken, JumpEX,
        output PCWrite, IFIDWrite, IDEXBubble, IFIDFlush, IDEXFlush, EXMEMFlush,
               ForwardA, ForwardB, HazState
    );
endinterface

// File: rtl/hazard_controller.sv
// Hazard detection / stall-flush sequencer for the 5-stage MIPS pipeline.
// Define HAZ_FORWARD_EN to enable EX-stage forwarding (only load-use then stalls).
module hazard_controller (
    input  logic                Clk,
    input  logic                Reset,
    hazard_controller_if.slave  hif
);
    localparam logic [1:0] RUN   = 2'd0;
    localparam logic [1:0] STALL = 2'd1;
    localparam logic [1:0] FLUSH = 2'd2;

    logic [1:0] state, state_nxt;
    logic [1:0] stall_cnt, cnt_nxt;
    logic [1:0] need;
    logic [1:0] fwd_a, fwd_b;
    logic       pc_wr, ifid_wr, bubble, ifid_fl, idex_fl, exmem_fl;

    function automatic logic src_match(input logic [4:0] src, input logic [4:0] rd,
                                       input logic we);
        return (src != 5'd0) && (src == rd) && we;
    endfunction

    function automatic logic id_hit(input logic [4:0] rs, input logic [4:0] rt,
                                    input logic uses_rt, input logic [4:0] rd,
                                    input logic we);
        return src_match(rs, rd, we) || (uses_rt && src_match(rt, rd, we));
    endfunction

`ifdef HAZ_FORWARD_EN
    // Loaded data is only available after MEM, so a load in EX costs one bubble.
    always_comb begin
        need = 2'd0;
        if (hif.EXMemRead &&
            id_hit(hif.IDRs, hif.IDRt, hif.IDUsesRt, hif.EXRd, hif.EXRegWrite))
            need = 2'd1;
    end

    always_comb begin
        fwd_a = 2'd0;
        fwd_b = 2'd0;
        if (src_match(hif.EXRs, hif.MEMRd, hif.MEMRegWrite))     fwd_a = 2'd2;
        else if (src_match(hif.EXRs, hif.WBRd, hif.WBRegWrite))  fwd_a = 2'd1;
        if (src_match(hif.EXRt, hif.MEMRd, hif.MEMRegWrite))     fwd_b = 2'd2;
        else if (src_match(hif.EXRt, hif.WBRd, hif.WBRegWrite))  fwd_b = 2'd1;
    end
`else
    // Without forwarding, wait until the youngest matching producer has written back.
    always_comb begin
        need = 2'd0;
        if (id_hit(hif.IDRs, hif.IDRt, hif.IDUsesRt, hif.EXRd, hif.EXRegWrite))
            need = 2'd3;
        else if (id_hit(hif.IDRs, hif.IDRt, hif.IDUsesRt, hif.MEMRd, hif.MEMRegWrite))
            need = 2'd2;
        else if (id_hit(hif.IDRs, hif.IDRt, hif.IDUsesRt, hif.WBRd, hif.WBRegWrite))
            need = 2'd1;
    end

    assign fwd_a = 2'd0;
    assign fwd_b = 2'd0;

    logic unused_fwd_inputs;
    assign unused_fwd_inputs = ^{hif.EXRs, hif.EXRt, hif.EXMemRead};
`endif

    always_comb begin
        state_nxt = state;
        cnt_nxt   = stall_cnt;
        pc_wr     = 1'b1;
        ifid_wr   = 1'b1;
        bubble    = 1'b0;
        ifid_fl   = 1'b0;
        idex_fl   = 1'b0;
        exmem_fl  = 1'b0;
        case (state)
            RUN: begin
                // Branch resolves in MEM, older than the jump in EX, so it wins.
                if (hif.BranchTaken) begin
                    ifid_fl   = 1'b1;
                    idex_fl   = 1'b1;
                    exmem_fl  = 1'b1;
                    state_nxt = FLUSH;
                end else if (hif.JumpEX) begin
                    ifid_fl = 1'b1;
                    idex_fl = 1'b1;
                end else if (need != 2'd0) begin
                    pc_wr     = 1'b0;
                    ifid_wr   = 1'b0;
                    bubble    = 1'b1;
                    cnt_nxt   = need - 2'd1;
                    state_nxt = (need > 2'd1) ? STALL : RUN;
                end
            end
            STALL: begin
                if (hif.BranchTaken) begin
                    ifid_fl   = 1'b1;
                    idex_fl   = 1'b1;
                    exmem_fl  = 1'b1;
                    cnt_nxt   = 2'd0;
                    state_nxt = FLUSH;
                end else begin
                    pc_wr   = 1'b0;
                    ifid_wr = 1'b0;
                    bubble  = 1'b1;
                    cnt_nxt = (stall_cnt != 2'd0) ? stall_cnt - 2'd1 : 2'd0;
                    if (stall_cnt <= 2'd1) state_nxt = RUN;
                end
            end
            FLUSH:   state_nxt = RUN;
            default: begin
                state_nxt = RUN;
                cnt_nxt   = 2'd0;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= RUN;
            stall_cnt <= 2'd0;
        end else begin
            state     <= state_nxt;
            stall_cnt <= cnt_nxt;
        end
    end

    assign hif.PCWrite    = pc_wr;
    assign hif.IFIDWrite  = ifid_wr;
    assign hif.IDEXBubble = bubble;
    assign hif.IFIDFlush  = ifid_fl;
    assign hif.IDEXFlush  = idex_fl;
    assign hif.EXMEMFlush = exmem_fl;
    assign hif.ForwardA   = fwd_a;
    assign hif.ForwardB   = fwd_b;
    assign hif.HazState   = state;
endmodule
